// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-port memory responder.
//   state_e            : responder FSM states
//   SelFull            : byte-lane select meaning a full-word store
//   PartialSel         : lane patterns that may be serviced by read-modify-write
//   is_legal_store_sel : true for SelFull or any PartialSel pattern
package mem_resp_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StCapture,
      StWrite,
      StResp
   } state_e;

   localparam logic [3:0] SelFull = 4'b1111;

   localparam int unsigned NumPartialSel = 6;
   localparam logic [3:0] PartialSel [NumPartialSel] = '{
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100
   };

   function automatic logic is_partial_sel(input logic [3:0] sel);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < int'(NumPartialSel); i++) begin
         if (sel == PartialSel[i]) hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic logic is_legal_store_sel(input logic [3:0] sel);
      return (sel == SelFull) || is_partial_sel(sel);
   endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational 4-lane byte merge.
//   old_i    : existing word
//   new_i    : incoming word
//   sel_i    : lane i takes new_i when sel_i[i]=1, otherwise old_i
//   merged_o : merged word
module byte_lane_merge (
   input  logic [31:0] old_i,
   input  logic [31:0] new_i,
   input  logic [3:0]  sel_i,
   output logic [31:0] merged_o
);

   always_comb begin
      merged_o = old_i;
      for (int i = 0; i < 4; i++) begin
         if (sel_i[i]) merged_o[8*i +: 8] = new_i[8*i +: 8];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder in front of a word-wide single-port SRAM without byte enables.
// Loads read one word; full stores write directly; legal partial stores do a
// read-modify-write; illegal store selects complete immediately with err_o.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   req_i, we_i, addr_i : request handshake (held until ack_o), direction, byte address
//   byte_select_i       : store lane enables
//   wdata_i             : lane-replicated store data
//   rdata_o             : last loaded word
//   ack_o, err_o        : completion pulse, illegal-select flag
//   sram_*              : SRAM macro port (read data one cycle after a read access)
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [ADDR_W+1:0] addr_i,
   input  logic [3:0]        byte_select_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              ack_o,
   output logic              err_o,
   output logic              sram_en_o,
   output logic              sram_we_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   output logic [31:0]       sram_wdata_o,
   input  logic [31:0]       sram_rdata_i
);

   state_e            state_q, state_d;
   logic              we_q;
   logic [ADDR_W-1:0] idx_q;
   logic [3:0]        sel_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic [31:0]       merge_q;
   logic              err_q;
   logic [31:0]       merged;
   logic              accept;

   // Byte offset within the word is irrelevant to a word-wide SRAM.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^addr_i[1:0];

   assign accept = (state_q == StIdle) && req_i;

   byte_lane_merge u_merge (
      .old_i    (sram_rdata_i),
      .new_i    (wdata_q),
      .sel_i    (sel_q),
      .merged_o (merged)
   );

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         idx_q   <= '0;
         sel_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         merge_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= we_i;
            idx_q   <= addr_i[ADDR_W+1:2];
            sel_q   <= byte_select_i;
            wdata_q <= wdata_i;
            err_q   <= we_i && !is_legal_store_sel(byte_select_i);
         end
         if (state_q == StCapture) begin
            if (we_q) merge_q <= merged;
            else      rdata_q <= sram_rdata_i;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req_i) begin
               if (!we_i)                                state_d = StRead;
               else if (byte_select_i == SelFull)        state_d = StWrite;
               else if (is_legal_store_sel(byte_select_i)) state_d = StRead;
               else                                      state_d = StResp;
            end
         end
         StRead:    state_d = StCapture;
         StCapture: state_d = we_q ? StWrite : StResp;
         StWrite:   state_d = StResp;
         StResp:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Outputs. SRAM strobes are masked by rst_i so a reset cycle can never commit a write.
   always_comb begin
      sram_en_o = 1'b0;
      sram_we_o = 1'b0;
      ack_o     = 1'b0;
      err_o     = 1'b0;
      unique case (state_q)
         StRead: sram_en_o = !rst_i;
         StWrite: begin
            sram_en_o = !rst_i;
            sram_we_o = !rst_i;
         end
         StResp: begin
            ack_o = 1'b1;
            err_o = err_q;
         end
         default: ;
      endcase
   end

   assign sram_addr_o  = idx_q;
   assign sram_wdata_o = (sel_q == SelFull) ? wdata_q : merge_q;
   assign rdata_o      = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          req_i = 1'b0;
   logic          we_i = 1'b0;
   logic [AW+1:0] addr_i = '0;
   logic [3:0]    byte_select_i = '0;
   logic [31:0]   wdata_i = '0;
   logic [31:0]   rdata_o;
   logic          ack_o;
   logic          err_o;
   logic          sram_en_o;
   logic          sram_we_o;
   logic [AW-1:0] sram_addr_o;
   logic [31:0]   sram_wdata_o;
   logic [31:0]   sram_rdata = '0;

   data_mem_responder #(.ADDR_W(AW)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .req_i         (req_i),
      .we_i          (we_i),
      .addr_i        (addr_i),
      .byte_select_i (byte_select_i),
      .wdata_i       (wdata_i),
      .rdata_o       (rdata_o),
      .ack_o         (ack_o),
      .err_o         (err_o),
      .sram_en_o     (sram_en_o),
      .sram_we_o     (sram_we_o),
      .sram_addr_o   (sram_addr_o),
      .sram_wdata_o  (sram_wdata_o),
      .sram_rdata_i  (sram_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vec = 0;
   int miss = 0;

   typedef struct {
      int          issue;
      int          lat;
      bit          is_load;
      bit          err;
      logic [31:0] rdata;
      int          ens;
      int          wrs;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] sram_mem [1<<AW];
   logic [31:0] ref_mem  [1<<AW];
   int          en_cnt = 0;
   int          wr_cnt = 0;
   int          we_total = 0;
   logic [31:0] last_load = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      vec++;
      if (act !== exp_v) begin
         miss++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   function automatic bit ref_partial(input logic [3:0] s);
      return s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100};
   endfunction

   // SRAM macro model: strobes sampled mid-cycle, effect applied just after the edge.
   initial begin
      logic          en_s, we_s;
      logic [AW-1:0] a_s;
      logic [31:0]   d_s;
      forever begin
         @(negedge clk);
         en_s = sram_en_o;
         we_s = sram_we_o;
         a_s  = sram_addr_o;
         d_s  = sram_wdata_o;
         @(posedge clk);
         #1;
         if (en_s) begin
            if (we_s) sram_mem[a_s] = d_s;
            else      sram_rdata    = sram_mem[a_s];
         end
      end
   end

   // Monitor: pops the scoreboard on every ack.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sram_en_o && sram_we_o) we_total++;
         if (rst_i) begin
            en_cnt    = 0;
            wr_cnt    = 0;
            last_load = '0;
         end else begin
            if (sram_en_o) en_cnt++;
            if (sram_en_o && sram_we_o) wr_cnt++;
            if (ack_o) begin
               if (sb.size() == 0) begin
                  vec++;
                  miss++;
                  $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
               end else begin
                  e = sb.pop_front();
                  chk("ack_latency", 32'(cyc - e.issue), 32'(e.lat));
                  chk("err", 32'(err_o), 32'(e.err));
                  if (e.is_load) begin
                     chk("load_rdata", rdata_o, e.rdata);
                     last_load = e.rdata;
                  end else begin
                     chk("rdata_hold", rdata_o, last_load);
                  end
                  chk("sram_en_count", 32'(en_cnt), 32'(e.ens));
                  chk("sram_wr_count", 32'(wr_cnt), 32'(e.wrs));
               end
               en_cnt = 0;
               wr_cnt = 0;
            end else begin
               chk("err_without_ack", 32'(err_o), 32'd0);
            end
         end
      end
   end

   // Drives a request (DUT must be in IDLE) and, if tracked, records the expected outcome.
   task automatic issue(input logic we, input logic [AW+1:0] addr, input logic [3:0] sel,
                        input logic [31:0] wd, input bit track);
      exp_t        e;
      int          w;
      logic [31:0] nw;
      req_i         = 1'b1;
      we_i          = we;
      addr_i        = addr;
      byte_select_i = sel;
      wdata_i       = wd;
      if (track) begin
         w         = int'(addr[AW+1:2]);
         e.issue   = cyc;
         e.is_load = !we;
         e.err     = 1'b0;
         e.rdata   = '0;
         e.wrs     = 0;
         if (!we) begin
            e.lat   = 3;
            e.ens   = 1;
            e.rdata = ref_mem[w];
         end else if (sel == 4'hF) begin
            e.lat      = 2;
            e.ens      = 1;
            e.wrs      = 1;
            ref_mem[w] = wd;
         end else if (ref_partial(sel)) begin
            e.lat = 4;
            e.ens = 2;
            e.wrs = 1;
            nw    = ref_mem[w];
            for (int b = 0; b < 4; b++) if (sel[b]) nw[8*b +: 8] = wd[8*b +: 8];
            ref_mem[w] = nw;
         end else begin
            e.lat = 1;
            e.ens = 0;
            e.err = 1'b1;
         end
         sb.push_back(e);
      end
   endtask

   // Waits for ack (bounded); scrambles the payload mid-flight. Returns just after the
   // edge that enters IDLE, with req_i still high.
   task automatic wait_ack();
      bit got = 0;
      @(posedge clk);
      #1;
      we_i          = 1'($urandom);
      addr_i        = (AW+2)'($urandom);
      byte_select_i = 4'($urandom);
      wdata_i       = $urandom;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (ack_o) begin
            got = 1;
            break;
         end
      end
      vec++;
      if (!got) begin
         miss++;
         $display("FAIL ack_timeout: got no ack expected one within 20 cycles");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_i = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic xact(input logic we, input logic [AW+1:0] addr, input logic [3:0] sel,
                       input logic [31:0] wd);
      issue(we, addr, sel, wd, 1);
      wait_ack();
      idle();
   endtask

   initial begin
      int          snap;
      int          kind;
      logic [3:0]  s;
      logic [3:0]  psel [6];
      psel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100};
      for (int i = 0; i < (1 << AW); i++) begin
         sram_mem[i] = '0;
         ref_mem[i]  = '0;
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", 32'(ack_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_sram_en", 32'(sram_en_o), 32'd0);
      chk("rst_sram_we", 32'(sram_we_o), 32'd0);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(posedge clk);
      #1;

      // Full store then load.
      xact(1'b1, 12'h010, 4'hF, 32'hDEADBEEF);
      xact(1'b0, 12'h010, 4'h0, 32'h0);
      // Partial stores.
      xact(1'b1, 12'h010, 4'b0010, 32'h55555555);
      chk("mem_merge_0010", sram_mem[4], 32'hDEAD55EF);
      xact(1'b1, 12'h013, 4'b1100, 32'h12341234);
      xact(1'b0, 12'h011, 4'h0, 32'h0);
      chk("mem_merge_1100", sram_mem[4], 32'h123455EF);
      // Illegal selects.
      snap = we_total;
      xact(1'b1, 12'h010, 4'b0101, 32'hFFFFFFFF);
      xact(1'b1, 12'h010, 4'b0000, 32'hFFFFFFFF);
      chk("illegal_no_write", 32'(we_total - snap), 32'd0);
      chk("illegal_mem", sram_mem[4], 32'h123455EF);

      // Reset during CAPTURE of a partial store.
      snap = we_total;
      issue(1'b1, 12'h010, 4'b0001, 32'hA5A5A5A5, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      req_i = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_capture_no_we", 32'(we_total - snap), 32'd0);
      xact(1'b0, 12'h010, 4'h0, 32'h0);

      // Reset during WRITE of a full store: the gated strobe must stay low.
      snap = we_total;
      issue(1'b1, 12'h010, 4'hF, 32'hCAFEF00D, 0);
      @(posedge clk); #1;
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      req_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_write_no_we", 32'(we_total - snap), 32'd0);
      xact(1'b0, 12'h010, 4'h0, 32'h0);

      // Reset coincident with a request in IDLE.
      snap = we_total;
      issue(1'b1, 12'h020, 4'hF, 32'h0BADF00D, 0);
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      req_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_idle_no_we", 32'(we_total - snap), 32'd0);
      xact(1'b0, 12'h020, 4'h0, 32'h0);

      // Back-to-back: store then load with req_i held across RESP.
      issue(1'b1, 12'h020, 4'hF, 32'h87654321, 1);
      wait_ack();
      issue(1'b0, 12'h021, 4'h0, 32'h0, 1);
      wait_ack();
      idle();

      // Randomized traffic over a small window of words.
      for (int t = 0; t < 120; t++) begin
         kind = int'($urandom_range(0, 3));
         case (kind)
            0: s = 4'($urandom);
            1: s = 4'hF;
            2: s = psel[$urandom_range(0, 5)];
            default: begin
               s = 4'($urandom);
               if (s == 4'hF || ref_partial(s)) s = 4'b1010;
            end
         endcase
         issue(kind != 0, {10'($urandom_range(0, 15)), 2'($urandom)}, s, $urandom, 1);
         wait_ack();
         if ($urandom_range(0, 1) == 1) idle();
      end
      idle();
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
